// File: rtl/cfg_pulse_gen_pkg.sv
// Shared field layout, state encoding and limits for the cfg-driven pulse generator.
package cfg_pulse_gen_pkg;

    localparam int PER_LSB    = 0;
    localparam int WID_LSB    = 32;
    localparam int NUM_LSB    = 48;
    localparam int RUN_BIT    = 63;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cfg_pulse_gen_phase_cnt.sv
// Wrap-around phase counter: counts 0..period-1 while enabled, load forces phase 0.
module pulse_phase_cnt #(
    parameter int PER_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic [PER_WIDTH-1:0] period,
    output logic [PER_WIDTH-1:0] phase_nxt_o,
    output logic                 wrap_o
);

    logic [PER_WIDTH-1:0] phase_q;
    logic [PER_WIDTH-1:0] phase_d;

    assign wrap_o = en && (phase_q == period - PER_WIDTH'(1));

    always_comb begin
        phase_d = phase_q;
        if (load) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = wrap_o ? '0 : phase_q + PER_WIDTH'(1);
        end
    end

    // Exposed so the registered pulse output can track the new phase on the same edge.
    assign phase_nxt_o = phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/cfg_pulse_gen.sv
// Programmable pulse train driven by the packed cfg word; P/W/N are shadowed on the run 0->1 edge.
module cfg_pulse_gen
    import cfg_pulse_gen_pkg::*;
#(
    parameter int CFG_DATA_WIDTH = 64,
    parameter int PER_WIDTH      = 32,
    parameter int WID_WIDTH      = 16,
    parameter int NUM_WIDTH      = 15
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [CFG_DATA_WIDTH-1:0] cfg_data,
    output logic                      pulse_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [NUM_WIDTH-1:0]      pulse_cnt_o
);

    logic [PER_WIDTH-1:0] cfg_per;
    logic [WID_WIDTH-1:0] cfg_wid;
    logic [NUM_WIDTH-1:0] cfg_num;
    logic                 run;
    logic [PER_WIDTH-1:0] cfg_per_m1;
    logic [WID_WIDTH-1:0] wid_clamp;
    logic                 start;

    assign cfg_per    = cfg_data[PER_LSB +: PER_WIDTH];
    assign cfg_wid    = cfg_data[WID_LSB +: WID_WIDTH];
    assign cfg_num    = cfg_data[NUM_LSB +: NUM_WIDTH];
    assign run        = cfg_data[RUN_BIT];
    assign cfg_per_m1 = cfg_per - PER_WIDTH'(1);

    // W >= P would leave no low time; clamp so every period has at least one low cycle.
    assign wid_clamp = ({{(PER_WIDTH-WID_WIDTH){1'b0}}, cfg_wid} >= cfg_per)
                       ? cfg_per_m1[WID_WIDTH-1:0] : cfg_wid;

    state_t               state_q, state_d;
    logic                 run_q;
    logic [PER_WIDTH-1:0] per_q, per_d;
    logic [WID_WIDTH-1:0] wid_q, wid_d;
    logic [NUM_WIDTH-1:0] num_q, num_d;
    logic [NUM_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pulse_q, pulse_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 ph_load, ph_en, ph_wrap;
    logic [PER_WIDTH-1:0] ph_nxt;
    logic [NUM_WIDTH-1:0] cnt_sat;

    assign start   = run && !run_q;
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + NUM_WIDTH'(1);

    pulse_phase_cnt #(
        .PER_WIDTH (PER_WIDTH)
    ) u_phase (
        .clk         (aclk),
        .rst         (areset),
        .load        (ph_load),
        .en          (ph_en),
        .period      (per_q),
        .phase_nxt_o (ph_nxt),
        .wrap_o      (ph_wrap)
    );

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        wid_d   = wid_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ph_load = 1'b0;
        ph_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_per < PER_WIDTH'(MIN_PERIOD)) begin
                        err_d = 1'b1;
                    end else begin
                        per_d   = cfg_per;
                        wid_d   = wid_clamp;
                        num_d   = cfg_num;
                        cnt_d   = '0;
                        ph_load = 1'b1;
                        state_d = RUN;
                        busy_d  = 1'b1;
                        pulse_d = (wid_clamp != '0);
                    end
                end
            end
            RUN: begin
                if (!run) begin
                    // Abort wins over a coincident wrap: count holds, no done strobe.
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    ph_en   = 1'b1;
                    pulse_d = (ph_nxt < {{(PER_WIDTH-WID_WIDTH){1'b0}}, wid_q});
                    if (ph_wrap) begin
                        cnt_d = cnt_sat;
                        if ((num_q != '0) && (cnt_sat == num_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            pulse_d = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            run_q   <= 1'b1;  // a run bit already high at reset release must not start
            per_q   <= '0;
            wid_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run;
            per_q   <= per_d;
            wid_q   <= wid_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pulse_o     = pulse_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pulse_cnt_o = cnt_q;

endmodule

// File: tb/tb_cfg_pulse_gen.sv
// Directed bench for cfg_pulse_gen: vector table of whole runs plus cycle-exact corner sequences.
module tb_cfg_pulse_gen;

    logic        aclk;
    logic        areset;
    logic [63:0] cfg_data;
    logic        pulse_o, busy_o, done_o, err_o;
    logic [14:0] pulse_cnt_o;

    int checks   = 0;
    int failures = 0;

    cfg_pulse_gen dut (
        .aclk        (aclk),
        .areset      (areset),
        .cfg_data    (cfg_data),
        .pulse_o     (pulse_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .pulse_cnt_o (pulse_cnt_o)
    );

    initial aclk = 1'b0;
    always #4 aclk = ~aclk;

    typedef struct {
        logic [31:0] per;
        logic [15:0] wid;
        logic [14:0] num;
        int          hold;
        logic        exp_busy1;
        int          exp_err;
        int          exp_hi;
        int          exp_done;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [63:0] mk(input logic run, input logic [14:0] n,
                                       input logic [15:0] w, input logic [31:0] p);
        return {run, n, w, p};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset;
        areset = 1'b1;
        #3;
        areset = 1'b0;
    endtask

    // Reset, arm run_q with run=0, then present the start word.
    task automatic arm(input logic [14:0] n, input logic [15:0] w, input logic [31:0] p);
        cfg_data = mk(1'b0, n, w, p);
        do_reset();
        tick();
        tick();
        cfg_data = mk(1'b1, n, w, p);
    endtask

    initial begin
        int hi, dn, er;
        areset   = 1'b0;
        cfg_data = '0;

        //            per  wid num hold busy1 err hi  done cnt
        vecs[0] = '{32'd10, 16'd3, 15'd4, 60, 1'b1, 0, 12, 1, 4};
        vecs[1] = '{32'd1,  16'd0, 15'd0, 10, 1'b0, 1, 0,  0, 0};
        vecs[2] = '{32'd0,  16'd5, 15'd2, 10, 1'b0, 1, 0,  0, 0};
        vecs[3] = '{32'd5,  16'd9, 15'd3, 30, 1'b1, 0, 12, 1, 3};
        vecs[4] = '{32'd8,  16'd2, 15'd0, 50, 1'b1, 0, 14, 0, 6};
        vecs[5] = '{32'd2,  16'd0, 15'd5, 20, 1'b1, 0, 0,  1, 5};
        vecs[6] = '{32'd3,  16'd1, 15'd2, 10, 1'b1, 0, 2,  1, 2};
        vecs[7] = '{32'd2,  16'd1, 15'd1, 5,  1'b1, 0, 1,  1, 1};
        vecs[8] = '{32'd10, 16'd0, 15'd2, 25, 1'b1, 0, 0,  1, 2};

        // Reset state and run already high at release: must not start.
        cfg_data = mk(1'b1, 15'd0, 16'd3, 32'd10);
        areset   = 1'b1;
        #2;
        chk("reset_pulse", pulse_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_cnt", pulse_cnt_o, 0);
        areset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("held_run_busy", busy_o, 0);
            chk("held_run_pulse", pulse_o, 0);
        end
        cfg_data[63] = 1'b0;
        tick();
        cfg_data[63] = 1'b1;
        tick();
        chk("rearm_busy", busy_o, 1);
        chk("rearm_pulse", pulse_o, 1);

        // Whole-run vectors.
        for (int v = 0; v < 9; v++) begin
            arm(vecs[v].num, vecs[v].wid, vecs[v].per);
            hi = 0; dn = 0; er = 0;
            for (int k = 0; k < vecs[v].hold; k++) begin
                tick();
                if (k == 0) chk($sformatf("v%0d_busy_first", v), busy_o, vecs[v].exp_busy1);
                hi += int'(pulse_o);
                dn += int'(done_o);
                er += int'(err_o);
            end
            cfg_data[63] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                hi += int'(pulse_o);
                dn += int'(done_o);
                er += int'(err_o);
            end
            chk($sformatf("v%0d_err", v), er, vecs[v].exp_err);
            chk($sformatf("v%0d_high_cycles", v), hi, vecs[v].exp_hi);
            chk($sformatf("v%0d_done", v), dn, vecs[v].exp_done);
            chk($sformatf("v%0d_cnt", v), pulse_cnt_o, vecs[v].exp_cnt);
            chk($sformatf("v%0d_busy_end", v), busy_o, 0);
            chk($sformatf("v%0d_pulse_end", v), pulse_o, 0);
        end

        // Cycle-exact shape and done timing for P=10 W=3 N=4.
        arm(15'd4, 16'd3, 32'd10);
        for (int k = 0; k < 45; k++) begin
            tick();
            chk($sformatf("shape_pulse_k%0d", k), pulse_o, int'((k < 40) && ((k % 10) < 3)));
            chk($sformatf("shape_done_k%0d", k), done_o, int'(k == 40));
            chk($sformatf("shape_busy_k%0d", k), busy_o, int'(k < 40));
        end
        chk("shape_cnt", pulse_cnt_o, 4);

        // Clamp shape: W=9 with P=5 behaves as W=4.
        arm(15'd0, 16'd9, 32'd5);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk($sformatf("clamp_pulse_k%0d", k), pulse_o, int'((k % 5) < 4));
        end

        // Shadowing: a P rewrite mid-run only applies at the next start.
        arm(15'd0, 16'd3, 32'd10);
        for (int k = 0; k < 21; k++) begin
            tick();
            if (k == 5) cfg_data = mk(1'b1, 15'd0, 16'd3, 32'd20);
            if (k == 9)  chk("shadow_cnt_e9", pulse_cnt_o, 0);
            if (k == 10) chk("shadow_cnt_e10", pulse_cnt_o, 1);
            if (k == 20) chk("shadow_cnt_e20", pulse_cnt_o, 2);
        end
        cfg_data[63] = 1'b0;
        tick();
        chk("abort_busy", busy_o, 0);
        chk("abort_cnt_hold", pulse_cnt_o, 2);
        tick();
        cfg_data[63] = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            if (k == 10) chk("newp_cnt_e10", pulse_cnt_o, 0);
            if (k == 20) chk("newp_cnt_e20", pulse_cnt_o, 1);
        end

        // Asynchronous reset in the middle of a high phase.
        arm(15'd0, 16'd5, 32'd10);
        tick();
        tick();
        chk("async_pre_pulse", pulse_o, 1);
        #1;
        areset = 1'b1;
        #1;
        chk("async_pulse", pulse_o, 0);
        chk("async_busy", busy_o, 0);
        chk("async_cnt", pulse_cnt_o, 0);
        areset = 1'b0;
        tick();
        chk("async_after_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfg_pulse_gen.md
Name: cfg_pulse_gen

Overview:
Consumes the packed cfg_data word produced by the AXI-lite configuration register and turns it into a programmable pulse train: period, high width, pulse count and a run bit.
Sits directly downstream of the cfg register in the PL fabric and drives trigger/gate logic for the acquisition and generation paths.
Parameters are shadowed at start so AXI writes during a run cannot glitch the output.

Parameters:
CFG_DATA_WIDTH, 64, width of cfg_data input; must be 64.
PER_WIDTH, 32, period field width, cfg_data[31:0].
WID_WIDTH, 16, high-width field width, cfg_data[47:32].
NUM_WIDTH, 15, pulse-count field width, cfg_data[62:48]; bit 63 is run.

Ports:
aclk  in  1  clock (125 MHz)
areset  in  1  asynchronous, active-high reset
cfg_data  in  CFG_DATA_WIDTH  configuration word from the cfg register
pulse_o  out  1  registered pulse output
busy_o  out  1  high while state is RUN
done_o  out  1  one-cycle strobe when the programmed count completes
err_o  out  1  one-cycle strobe when a start is rejected
pulse_cnt_o  out  NUM_WIDTH  completed periods since the last start

Behaviour:
- Reset (async assert, sync release): state IDLE; pulse_o, busy_o, done_o, err_o = 0; pulse_cnt_o = 0; phase counter = 0.
- Reset sets the run_q history register to 1, so a run bit already high at reset release does NOT start the block. Software must write 0 and then 1.
- Start event: run=1 and run_q=0 at a clock edge, where run = cfg_data[63]. run_q <= run every cycle.
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE + start, with P=cfg_data[31:0] < 2:
  - err_o strobes on that edge; stay IDLE; nothing latched.
- IDLE + start, otherwise:
  - On the same edge latch P, W=cfg_data[47:32] and N=cfg_data[62:48].
  - If W >= P, clamp W to P-1. W=0 is legal and gives pulse_o constantly low.
  - phase <= 0, pulse_cnt_o <= 0, state <= RUN, busy_o <= 1, pulse_o <= (W != 0).
  - Latency: pulse_o rises on the first edge at which the cfg register output shows run=1.
- RUN, each cycle:
  - phase increments and wraps P-1 -> 0. pulse_o is high exactly while phase < W, giving W cycles high and P-W cycles low.
  - On the wrap, pulse_cnt_o increments, saturating at all-ones.
  - If N != 0 and the wrap completes period N: state <= DONE, done_o strobes, busy_o <= 0, pulse_o <= 0, pulse_cnt_o = N.
  - N=0 means continuous operation until run falls.
- RUN + run=0 (abort):
  - Takes priority over wrap/done on the same edge.
  - state <= IDLE, pulse_o <= 0, busy_o <= 0, no done_o; pulse_cnt_o holds its value.
- DONE: hold until run=0, then IDLE. No restart occurs without a fresh 0->1 run edge.
- Changes to the P/W/N fields while in RUN are ignored until the next start.
- areset asserted mid-run forces all outputs to 0 asynchronously.

Decomposition:
- cfg_pulse_gen_pkg holds:
  - field offsets/widths: PER_LSB=0, WID_LSB=32, NUM_LSB=48, RUN_BIT=63;
  - the state enum typedef {IDLE, RUN, DONE};
  - MIN_PERIOD=2.
- One sub-module, pulse_phase_cnt: a wrap-around phase counter with load, enable and wrap strobe outputs (PER_WIDTH). The FSM and output logic live in the top.

Test Plan:
- Reset with run=1 held, then release -> no pulse, busy_o=0 for 20 cycles; write run=0 then run=1 -> busy_o=1.
- P=10, W=3, N=4, run 0->1 -> pulse_o high 3 / low 7 cycles, 4 times. done_o strobes exactly once at cycle 40 after start, pulse_cnt_o=4, then DONE.
- P=1, run 0->1 -> err_o single strobe, busy_o stays 0, pulse_o stays 0.
- P=5, W=9 -> clamped to W=4: pulse_o high 4 cycles, low 1 cycle per period.
- N=0, P=8, W=2, run high for 50 cycles then 0 -> 6 full periods counted. pulse_o low on the edge after run falls, no done_o.
- During RUN with P=10, rewrite P=20 -> the period stays 10 until the next start edge, then becomes 20.
- Assert areset mid-high phase -> pulse_o and busy_o drop immediately, without waiting for a clock edge.
